// File: rtl/tdp_bram_pkg.sv
// Shared constants and helpers for the byte-enable true dual-port RAM.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package tdp_bram_pkg;

  localparam int MAX_READ_LATENCY = 3;
  localparam int COLL_CNT_W       = 16;

  // Number of bits needed to represent value (value >= 1).
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tdp_bram_be_if.sv
// One RAM access port: request (en/we/addr/wdata) and read response (rdata/rvalid).
// Latency: response arrives READ_LATENCY cycles after a read request.
// Backpressure: none; the RAM accepts one request per cycle unconditionally.
interface tdp_bram_be_if #(
  parameter int WIDTH  = 64,
  parameter int BYTE_W = 8,
  parameter int DEPTH  = 2048
);
  import tdp_bram_pkg::*;

  localparam int NB = WIDTH / BYTE_W;
  localparam int AW = clogb2(DEPTH - 1);

  logic             en;
  logic [NB-1:0]    we;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;

  modport master (output en, we, addr, wdata, input rdata, rvalid);
  modport slave  (input en, we, addr, wdata, output rdata, rvalid);

endinterface

// File: rtl/tdp_bram_rd_pipe.sv
// Read-data delay line: stage 0 captures RAM data on a read, later stages shift it out.
// Latency: READ_LATENCY cycles from rd_i to rvalid_o; each stage holds its data when idle.
// Backpressure: none; synchronous rst drops every in-flight read and zeroes the data.
module tdp_bram_rd_pipe #(
  parameter int WIDTH        = 64,
  parameter int READ_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_i,
  input  logic [WIDTH-1:0] rd_data_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             rvalid_o
);

  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [WIDTH-1:0]        dat_q [READ_LATENCY];
  logic [WIDTH-1:0]        dat_d [READ_LATENCY];

  // A stage only loads when a valid read reaches it, so the last stage keeps the last read value.
  always_comb begin
    vld_d    = '0;
    dat_d    = dat_q;
    vld_d[0] = rd_i;
    if (rd_i) dat_d[0] = rd_data_i;
    for (int k = 1; k < READ_LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
      if (vld_q[k-1]) dat_d[k] = dat_q[k-1];
    end
  end

  // Stage registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < READ_LATENCY; k++) dat_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign rdata_o  = dat_q[READ_LATENCY-1];
  assign rvalid_o = vld_q[READ_LATENCY-1];

endmodule

// File: rtl/tdp_bram_be.sv
// True dual-port RAM with byte enables, read-first collisions (port A wins write overlaps).
// Latency: READ_LATENCY (1..3) cycles read-to-rvalid; coll pulses the cycle after a collision.
// Backpressure: none. Macro TDP_BRAM_COLL_CNT_EN enables the saturating collision counter.
module tdp_bram_be
  import tdp_bram_pkg::*;
#(
  parameter int    WIDTH        = 64,
  parameter int    BYTE_W       = 8,
  parameter int    DEPTH        = 2048,
  parameter int    READ_LATENCY = 2,
  parameter string INIT_FILE    = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  tdp_bram_be_if.slave          a,
  tdp_bram_be_if.slave          b,
  output logic                  coll,
  output logic [COLL_CNT_W-1:0] coll_cnt
);

  localparam int NB = WIDTH / BYTE_W;

  if (WIDTH % BYTE_W != 0) begin : g_bad_width
    $error("tdp_bram_be: WIDTH must be a multiple of BYTE_W");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("tdp_bram_be: READ_LATENCY must be 1..3");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("tdp_bram_be: DEPTH must be at least 2");
  end

  (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

  // Power-up contents: all zeros.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  logic             a_rd, b_rd, a_wr, b_wr;
  logic [WIDTH-1:0] a_mem_rd, b_mem_rd;
  logic             coll_d, coll_q;

  // Requests presented during rst are discarded.
  always_comb begin
    a_rd     = a.en && (a.we == '0) && !rst;
    b_rd     = b.en && (b.we == '0) && !rst;
    a_wr     = a.en && (a.we != '0) && !rst;
    b_wr     = b.en && (b.we != '0) && !rst;
    a_mem_rd = mem[a.addr];
    b_mem_rd = mem[b.addr];
    coll_d   = (a.en && b.en && (a.addr == b.addr) && (a_wr || b_wr));
  end

  // Byte-lane writes; port A is applied last so it owns overlapping lanes on a collision.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (b_wr && b.we[i]) mem[b.addr][i*BYTE_W +: BYTE_W] <= b.wdata[i*BYTE_W +: BYTE_W];
      if (a_wr && a.we[i]) mem[a.addr][i*BYTE_W +: BYTE_W] <= a.wdata[i*BYTE_W +: BYTE_W];
    end
  end

  tdp_bram_rd_pipe #(.WIDTH(WIDTH), .READ_LATENCY(READ_LATENCY)) u_rd_pipe_a (
    .clk       (clk),
    .rst       (rst),
    .rd_i      (a_rd),
    .rd_data_i (a_mem_rd),
    .rdata_o   (a.rdata),
    .rvalid_o  (a.rvalid)
  );

  tdp_bram_rd_pipe #(.WIDTH(WIDTH), .READ_LATENCY(READ_LATENCY)) u_rd_pipe_b (
    .clk       (clk),
    .rst       (rst),
    .rd_i      (b_rd),
    .rd_data_i (b_mem_rd),
    .rdata_o   (b.rdata),
    .rvalid_o  (b.rvalid)
  );

  // One-cycle collision pulse.
  always_ff @(posedge clk) begin
    if (rst) coll_q <= 1'b0;
    else     coll_q <= coll_d;
  end

  assign coll = coll_q;

`ifdef TDP_BRAM_COLL_CNT_EN
  logic [COLL_CNT_W-1:0] coll_cnt_q, coll_cnt_d;

  // Saturating collision count, updated on the same edge that raises coll.
  always_comb begin
    coll_cnt_d = coll_cnt_q;
    if (coll_d && (coll_cnt_q != {COLL_CNT_W{1'b1}})) coll_cnt_d = coll_cnt_q + 1'b1;
  end

  // Counter register, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) coll_cnt_q <= '0;
    else     coll_cnt_q <= coll_cnt_d;
  end

  assign coll_cnt = coll_cnt_q;
`else
  assign coll_cnt = '0;
`endif

endmodule

// File: tb/tb_tdp_bram_be.sv
// Self-checking bench for tdp_bram_be: queue-based reference model plus directed literal checks.
module tb_tdp_bram_be;

  localparam int RL = 2;
`ifdef TDP_BRAM_COLL_CNT_EN
  localparam bit CNT_EN  = 1'b1;
  localparam int N_SAT   = 65540;
`else
  localparam bit CNT_EN  = 1'b0;
  localparam int N_SAT   = 40;
`endif

  logic        clk;
  logic        rst;
  logic        coll;
  logic [15:0] coll_cnt;

  int checks = 0;
  int errors = 0;

  tdp_bram_be_if #(.WIDTH(64), .BYTE_W(8), .DEPTH(2048)) a_if ();
  tdp_bram_be_if #(.WIDTH(64), .BYTE_W(8), .DEPTH(2048)) b_if ();

  tdp_bram_be #(
    .WIDTH(64), .BYTE_W(8), .DEPTH(2048), .READ_LATENCY(RL), .INIT_FILE("")
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a_if),
    .b        (b_if),
    .coll     (coll),
    .coll_cnt (coll_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [63:0] d;
  } pend_t;

  logic [63:0] m_mem [2048];
  pend_t       qa [$];
  pend_t       qb [$];
  int          cyc_n = 0;
  logic        e_av = 0, e_bv = 0, e_coll = 0;
  logic [63:0] e_ad = 0, e_bd = 0;
  logic [15:0] e_cnt = 0;

  initial for (int i = 0; i < 2048; i++) m_mem[i] = 64'h0;

  function automatic logic [63:0] lane_mask(input logic [7:0] we);
    logic [63:0] m;
    m = 64'h0;
    for (int i = 0; i < 8; i++) if (we[i]) m = m | (64'hFF << (8 * i));
    return m;
  endfunction

  always @(posedge clk) begin
    logic        collide;
    logic [63:0] am, bm, old;
    cyc_n = cyc_n + 1;
    if (rst) begin
      qa.delete();
      qb.delete();
      e_av = 0; e_bv = 0; e_ad = 0; e_bd = 0; e_coll = 0; e_cnt = 0;
    end else begin
      collide = a_if.en && b_if.en && (a_if.addr == b_if.addr) &&
                ((a_if.we != 0) || (b_if.we != 0));
      // reads see contents before this edge's writes
      if (a_if.en && a_if.we == 0) qa.push_back('{cyc_n + RL - 1, m_mem[a_if.addr]});
      if (b_if.en && b_if.we == 0) qb.push_back('{cyc_n + RL - 1, m_mem[b_if.addr]});
      am = a_if.en ? lane_mask(a_if.we) : 64'h0;
      bm = b_if.en ? lane_mask(b_if.we) : 64'h0;
      if (a_if.en && b_if.en && a_if.addr == b_if.addr) begin
        old = m_mem[a_if.addr];
        m_mem[a_if.addr] = (old & ~am & ~bm) | (b_if.wdata & bm & ~am) | (a_if.wdata & am);
      end else begin
        if (bm != 0) m_mem[b_if.addr] = (m_mem[b_if.addr] & ~bm) | (b_if.wdata & bm);
        if (am != 0) m_mem[a_if.addr] = (m_mem[a_if.addr] & ~am) | (a_if.wdata & am);
      end
      e_coll = collide;
      if (CNT_EN && collide && e_cnt != 16'hFFFF) e_cnt = e_cnt + 1;
      e_av = 0;
      e_bv = 0;
      if (qa.size() > 0 && qa[0].due == cyc_n) begin
        e_av = 1; e_ad = qa[0].d; void'(qa.pop_front());
      end
      if (qb.size() > 0 && qb[0].due == cyc_n) begin
        e_bv = 1; e_bd = qb[0].d; void'(qb.pop_front());
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    chk("m_a_rvalid", a_if.rvalid, e_av);
    chk("m_a_rdata",  a_if.rdata,  e_ad);
    chk("m_b_rvalid", b_if.rvalid, e_bv);
    chk("m_b_rdata",  b_if.rdata,  e_bd);
    chk("m_coll",     coll,        e_coll);
    chk("m_coll_cnt", coll_cnt,    e_cnt);
  end

  // ---------------- stimulus ----------------
  task automatic set_a(input logic en, input logic [7:0] we, input logic [10:0] addr,
                       input logic [63:0] d);
    a_if.en = en; a_if.we = we; a_if.addr = addr; a_if.wdata = d;
  endtask

  task automatic set_b(input logic en, input logic [7:0] we, input logic [10:0] addr,
                       input logic [63:0] d);
    b_if.en = en; b_if.we = we; b_if.addr = addr; b_if.wdata = d;
  endtask

  // Let one rising edge consume the current inputs, then return to idle.
  task automatic cyc();
    @(negedge clk);
    set_a(0, 8'h00, 11'd0, 64'h0);
    set_b(0, 8'h00, 11'd0, 64'h0);
  endtask

  task automatic rd_a_check(input string name, input logic [10:0] addr, input logic [63:0] exp);
    set_a(1, 8'h00, addr, 64'h0);
    cyc();
    repeat (RL - 1) cyc();
    chk({name, "_vld"}, a_if.rvalid, 1'b1);
    chk(name, a_if.rdata, exp);
  endtask

  task automatic rd_b_check(input string name, input logic [10:0] addr, input logic [63:0] exp);
    set_b(1, 8'h00, addr, 64'h0);
    cyc();
    repeat (RL - 1) cyc();
    chk({name, "_vld"}, b_if.rvalid, 1'b1);
    chk(name, b_if.rdata, exp);
  endtask

  initial begin
    rst = 1'b1;
    set_a(0, 8'h00, 11'd0, 64'h0);
    set_b(0, 8'h00, 11'd0, 64'h0);
    repeat (3) @(negedge clk);
    chk("rst_a_rdata", a_if.rdata, 64'h0);
    chk("rst_a_rvalid", a_if.rvalid, 1'b0);
    chk("rst_b_rdata", b_if.rdata, 64'h0);
    chk("rst_coll", coll, 1'b0);
    chk("rst_coll_cnt", coll_cnt, 16'h0);
    rst = 1'b0;

    // Full write then read with exact latency and hold afterwards.
    set_a(1, 8'hFF, 11'd5, 64'h1122334455667788);
    cyc();
    set_a(1, 8'h00, 11'd5, 64'h0);
    cyc();
    chk("t1_early_vld", a_if.rvalid, 1'b0);
    repeat (RL - 1) cyc();
    chk("t1_vld", a_if.rvalid, 1'b1);
    chk("t1_data", a_if.rdata, 64'h1122334455667788);
    set_a(1, 8'hFF, 11'd6, 64'hDEADBEEFDEADBEEF);
    cyc();
    cyc();
    chk("t1_vld_pulse", a_if.rvalid, 1'b0);
    chk("t1_hold", a_if.rdata, 64'h1122334455667788);

    // Partial byte-lane write.
    set_a(1, 8'hFF, 11'd9, 64'hFFFFFFFFFFFFFFFF);
    cyc();
    set_a(1, 8'h0F, 11'd9, 64'h0);
    cyc();
    rd_a_check("t2_partial", 11'd9, 64'hFFFFFFFF00000000);
    rd_b_check("t2_partial_b", 11'd9, 64'hFFFFFFFF00000000);

    // Write/write collision: A owns overlapping lanes.
    set_a(1, 8'h0F, 11'd3, 64'hAAAAAAAAAAAAAAAA);
    set_b(1, 8'hFF, 11'd3, 64'hBBBBBBBBBBBBBBBB);
    cyc();
    chk("t3_coll", coll, 1'b1);
    chk("t3_cnt", coll_cnt, CNT_EN ? 16'd1 : 16'd0);
    cyc();
    chk("t3_coll_pulse", coll, 1'b0);
    rd_a_check("t3_merge", 11'd3, 64'hBBBBBBBBAAAAAAAA);

    // Read/write collision: read-first.
    set_a(1, 8'hFF, 11'd7, 64'h1);
    cyc();
    set_a(1, 8'h00, 11'd7, 64'h0);
    set_b(1, 8'hFF, 11'd7, 64'h2);
    cyc();
    chk("t4_coll", coll, 1'b1);
    chk("t4_cnt", coll_cnt, CNT_EN ? 16'd2 : 16'd0);
    repeat (RL - 1) cyc();
    chk("t4_old", a_if.rdata, 64'h1);
    rd_a_check("t4_new", 11'd7, 64'h2);

    // Two reads of the same address do not collide.
    set_a(1, 8'h00, 11'd5, 64'h0);
    set_b(1, 8'h00, 11'd5, 64'h0);
    cyc();
    chk("t4_rr_nocoll", coll, 1'b0);
    repeat (RL) cyc();

    // Reset with reads in flight on port B.
    set_b(1, 8'h00, 11'd5, 64'h0);
    cyc();
    set_b(1, 8'h00, 11'd9, 64'h0);
    cyc();
    set_b(1, 8'h00, 11'd3, 64'h0);
    set_a(1, 8'hFF, 11'd5, 64'h0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_no_vld", b_if.rvalid, 1'b0);
      chk("t5_rdata0", b_if.rdata, 64'h0);
      cyc();
    end
    chk("t5_cnt_clr", coll_cnt, 16'h0);
    rd_b_check("t5_mem_kept", 11'd5, 64'h1122334455667788);

    // Many collisions: saturation (or stuck at zero without the counter).
    for (int i = 0; i < N_SAT; i++) begin
      set_a(1, 8'hFF, 11'd100, 64'(i));
      set_b(1, 8'hF0, 11'd100, 64'hCCCCCCCCCCCCCCCC);
      cyc();
    end
    cyc();
    chk("t6_cnt_final", coll_cnt, CNT_EN ? 16'hFFFF : 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout expected completion");
    errors = errors + 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
